boot_fetch_unit: RTL and testbench
==================================

// Module: boot_fetch_unit
// PURPOSE
//   Instruction fetch front end for one core. Runs the boot-ROM fetch PC and drives the ROM's
//   req/addr. Collects the 1-cycle-latency ROM responses into a small prefetch FIFO. Presents
//   {pc, instr} to decode over a valid/ready handshake and handles redirects (jump/branch/trap).
// PARAMETERS
//   CORE_ID     0       core index; selects reset PC via boot_fetch_pkg::reset_pc(CORE_ID)
//   FIFO_DEPTH  4       prefetch entries; power of 2, >= 2
//   ADDR_WIDTH  12      fetch address width (ROM byte address space, 4 KiB)
//   DATA_WIDTH  32      instruction width
// PORTS
//   i_clk             in   1           clock; single clock domain
//   i_rst             in   1           reset; synchronous, active-high
//   i_fetch_en        in   1           1 = fetch allowed; 0 = stop issuing (sleep/WFI)
//   i_redirect_valid  in   1           redirect PC this cycle
//   i_redirect_pc     in   ADDR_WIDTH  redirect target (byte address)
//   o_rom_req         out  1           ROM read request
//   o_rom_addr        out  ADDR_WIDTH  ROM byte address, bits[1:0] always 0
//   i_rom_data        in   DATA_WIDTH  ROM read data, valid 1 cycle after req
//   i_rom_valid       in   1           ROM data valid
//   o_instr_valid     out  1           FIFO head valid to decode
//   o_instr           out  DATA_WIDTH  head instruction
//   o_instr_pc        out  ADDR_WIDTH  head PC
//   i_instr_ready     in   1           decode accepts head
//   o_misaligned      out  1           1-cycle pulse: redirect target had pc[1:0]!=0
// BEHAVIOUR
//   Reset: pc=reset_pc(CORE_ID) (0x000 for all cores); FIFO empty; inflight=0; state=ST_IDLE.
//     All outputs 0 except o_rom_addr=pc. Reset has priority over every other input.
//   FSM: ST_IDLE -> ST_RUN when i_fetch_en=1. ST_RUN -> ST_IDLE when i_fetch_en=0.
//     Any state -> ST_FLUSH on i_redirect_valid with inflight=1.
//     ST_FLUSH -> ST_RUN (or ST_IDLE if !i_fetch_en) after 1 cycle; the ROM response in that
//     cycle is discarded.
//   Issue (ST_RUN only): o_rom_req=1 iff (count + inflight) < FIFO_DEPTH and no redirect this
//     cycle. o_rom_addr=pc. On issue: pc <= pc+4, inflight <= 1. Max 1 request per cycle.
//   PC wrap-around: pc is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH (0xFFC+4 -> 0x000).
//   Response: i_rom_valid && inflight && state!=ST_FLUSH -> enqueue {issued_pc, i_rom_data}.
//     i_rom_valid without inflight is ignored (stale ROM output after a reset).
//   FIFO: registered pointers; o_instr_valid = !empty. Dequeue on o_instr_valid && i_instr_ready.
//     Full and empty are exact. Enqueue and dequeue in the same cycle keep count unchanged,
//     including when full, because the issue rule reserves the slot.
//   Redirect: pc <= {i_redirect_pc[ADDR_WIDTH-1:2],2'b00}. FIFO flushed the same cycle.
//     The next request issues in the following cycle (ST_RUN) or after ST_FLUSH.
//     o_misaligned pulses if i_redirect_pc[1:0]!=0.
//     Redirect + dequeue in the same cycle: the handshake completes and the FIFO is still
//     cleared. Redirect in ST_IDLE updates pc only.
//   i_fetch_en drop mid-run: no new issue; an in-flight response is still enqueued; FIFO is
//     retained.
//   Latency: a redirect becomes the first valid instr at decode 3 cycles later (no flush needed).
// CONFIGURATION
//   BOOT_FETCH_PERF_EN defined: adds outputs o_perf_fetched[31:0] (count of enqueues) and
//     o_perf_stall[31:0] (cycles in ST_RUN with the issue blocked by a full FIFO). Both are
//     free-running, wrap at 2^32, and reset to 0.
//   Not defined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//   boot_fetch_pkg: fetch_state_e {ST_IDLE, ST_RUN, ST_FLUSH}; fetch_entry_t {pc, instr};
//     PC_INC=4; function reset_pc(core_id).
//   Sub-module fetch_fifo (parameterised on FIFO_DEPTH, entry type fetch_entry_t): push, pop,
//     flush, full, empty, count. Flush has priority over push.
//   Top holds the FSM, pc, the inflight flag and issued_pc.
// TESTING
//   1 Reset, fetch_en=1, ready=1, ROM model: o_instr_pc 0x000,0x004,0x008... back-to-back
//     from cycle 2.
//   2 ready=0 for 10 cycles: exactly FIFO_DEPTH enqueues, then req=0. Release ready: the
//     stream resumes in order with no loss or duplicate.
//   3 Redirect to 0x040 while inflight: the stale response is dropped and the next instr_pc
//     is 0x040. Redirect to 0x043: o_misaligned=1 and fetch resumes from 0x040.
//   4 Redirect to 0xFF8, run: PCs 0xFF8, 0xFFC, 0x000, 0x004.
//   5 fetch_en dropped with one request in flight: that response is enqueued, no further req.
//     Re-enable: fetch resumes at the next pc.
//   6 Assert i_rst mid-stream while the ROM holds valid high: the FIFO is empty next cycle
//     and the stale valid is ignored. With BOOT_FETCH_PERF_EN, the counters match the
//     scoreboard.

Source files
------------

// File: rtl/boot_fetch_pkg.sv
// Shared types and constants for the boot fetch front end.
//   fetch_state_e : fetch controller states
//   fetch_entry_t : one prefetch FIFO entry {pc, instr} at the default 12/32-bit widths
//   PC_INC        : byte stride between sequential fetches
//   reset_pc()    : boot PC for a given core index
package boot_fetch_pkg;

  localparam int PC_INC       = 4;
  localparam int FETCH_ADDR_W = 12;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Every core currently boots from 0x000; the case keeps room for per-core vectors.
  function automatic logic [31:0] reset_pc(input int core_id);
    case (core_id)
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched {pc, instr} entries.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_push        write i_push_data (accepted when not full, or full with a pop)
//   i_pop         remove head (ignored when empty)
//   i_flush       clear all entries; wins over a simultaneous push
//   o_head        head entry (undefined content when empty)
//   o_full        count == DEPTH
//   o_empty       count == 0
//   o_count       current occupancy
module fetch_fifo
  import boot_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type T_ENTRY = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  T_ENTRY         i_push_data,
  input  logic           i_pop,
  input  logic           i_flush,
  output T_ENTRY         o_head,
  output logic           o_full,
  output logic           o_empty,
  output logic [PTR_W:0] o_count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  T_ENTRY           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush && !i_rst) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/boot_fetch_unit.sv
// Boot-ROM instruction fetch front end for one core.
// Drives the ROM request/address from the fetch PC, captures the 1-cycle ROM responses
// into a prefetch FIFO, and presents {pc, instr} to decode over valid/ready. Redirects
// (jump/branch/trap) reload the PC and clear the FIFO.
// Optional build macro: BOOT_FETCH_PERF_EN adds o_perf_fetched / o_perf_stall counters.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_fetch_en          1 = fetching allowed
//   i_redirect_valid/pc redirect request and byte target
//   o_rom_req/addr      ROM read request, word-aligned byte address
//   i_rom_data/valid    ROM response, one cycle after the request
//   o_instr_valid/instr/o_instr_pc, i_instr_ready   decode handshake (FIFO head)
//   o_misaligned        one-cycle pulse after a redirect whose target had pc[1:0] != 0
//   o_perf_fetched/o_perf_stall (BOOT_FETCH_PERF_EN only) enqueue / full-stall counts
//
// state    | meaning
// ST_IDLE  | not issuing; FIFO contents retained
// ST_RUN   | issuing sequential fetches while FIFO space allows
// ST_FLUSH | one dead cycle after a redirect with a request in flight; response dropped
module boot_fetch_unit
  import boot_fetch_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fetch_en,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_rom_req,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  input  logic                  i_rom_valid,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready,
  output logic                  o_misaligned
`ifdef BOOT_FETCH_PERF_EN
  ,
  output logic [31:0]           o_perf_fetched,
  output logic [31:0]           o_perf_stall
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  localparam int                    CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RESET_PC  = ADDR_WIDTH'(reset_pc(CORE_ID));
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(PC_INC);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_issued_pc;
  logic                  r_inflight;
  logic                  r_misaligned;

  logic                  w_issue;
  logic                  w_space_ok;
  logic                  w_accept;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_occupancy;
  entry_t                w_push_entry;
  entry_t                w_head;

  // Count the in-flight request as occupied so its response always has a slot.
  assign w_occupancy = w_count + CNT_W'(r_inflight);
  assign w_space_ok  = !w_full && (w_occupancy < DEPTH_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_flush     = 1'b0;

    w_issue  = (r_state == ST_RUN) && i_fetch_en && !i_redirect_valid && w_space_ok;
    w_accept = i_rom_valid && r_inflight && (r_state != ST_FLUSH);
    // In idle a redirect only moves the PC; buffered entries stay put.
    w_flush  = i_redirect_valid && (r_state != ST_IDLE);

    if (i_redirect_valid && r_inflight) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_fetch_en)  w_state_nxt = ST_RUN;
        ST_RUN:   if (!i_fetch_en) w_state_nxt = ST_IDLE;
        ST_FLUSH: w_state_nxt = i_fetch_en ? ST_RUN : ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_issued_pc  <= RESET_PC;
      r_inflight   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_misaligned <= i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);

      if (i_redirect_valid) begin
        r_pc <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_issue) begin
        r_pc <= r_pc + PC_STEP;
      end

      // A response (kept or dropped) or the flush cycle retires the outstanding request.
      if (w_issue) begin
        r_inflight  <= 1'b1;
        r_issued_pc <= r_pc;
      end else if (i_rom_valid || (r_state == ST_FLUSH)) begin
        r_inflight  <= 1'b0;
      end
    end
  end

  assign w_push_entry = '{pc: r_issued_pc, instr: i_rom_data};
  assign w_pop        = !w_empty && i_instr_ready;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .T_ENTRY (entry_t)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_accept),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign o_rom_req     = w_issue;
  assign o_rom_addr    = r_pc;
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_empty ? '0 : w_head.instr;
  assign o_instr_pc    = w_empty ? '0 : w_head.pc;
  assign o_misaligned  = r_misaligned;

`ifdef BOOT_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (r_state == ST_RUN) && i_fetch_en && !i_redirect_valid && !w_space_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_accept && !w_flush) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_stall)              r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_boot_fetch_unit.sv
module tb_boot_fetch_unit;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redir_v = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          rom_valid = 1'b0;
  logic          rom_hold = 1'b0;
  logic          iv;
  logic [DW-1:0] instr;
  logic [AW-1:0] ipc;
  logic          ready = 1'b0;
  logic          mis;
`ifdef BOOT_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  boot_fetch_unit #(.CORE_ID(0), .FIFO_DEPTH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fetch_en       (fetch_en),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .o_rom_req        (rom_req),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data),
    .i_rom_valid      (rom_valid),
    .o_instr_valid    (iv),
    .o_instr          (instr),
    .o_instr_pc       (ipc),
    .i_instr_ready    (ready),
    .o_misaligned     (mis)
`ifdef BOOT_FETCH_PERF_EN
    ,
    .o_perf_fetched   (perf_fetched),
    .o_perf_stall     (perf_stall)
`endif
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {20'hC0DE0, a};
  endfunction

  // ROM: one-cycle read latency; rom_hold forces a stuck valid.
  always @(posedge clk) begin
    rom_valid <= rom_hold | rom_req;
    rom_data  <= rom_word(rom_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [AW-1:0] p, input logic y);
    @(posedge clk);
    #1;
    rst = r; fetch_en = f; redir_v = v; redir_pc = p; ready = y;
    @(negedge clk);
  endtask

  typedef struct {
    logic          fe;
    logic          rv;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          req;
    logic [AW-1:0] addr;
    logic          v;
    logic [AW-1:0] pc;
    logic          mis;
  } vec_t;

  vec_t          tbl [16];
  logic          wr_v    [6];
  logic [AW-1:0] wr_pc   [6];
  logic [AW-1:0] wr_addr [6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int nreq;
    int got;
    logic [AW-1:0] exp_pc;

    //             fe    rv    rpc      rdy   req   addr     v     pc       mis
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h004, 1'b0, 12'h000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h008, 1'b1, 12'h000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h00C, 1'b1, 12'h004, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 12'h043, 1'b1, 1'b0, 12'h010, 1'b1, 12'h008, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h040, 1'b0, 12'h000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h040, 1'b0, 12'h000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h044, 1'b0, 12'h000, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h048, 1'b1, 12'h040, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h04C, 1'b1, 12'h044, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h04C, 1'b1, 12'h044, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h04C, 1'b1, 12'h044, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h04C, 1'b1, 12'h048, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h050, 1'b0, 12'h000, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h054, 1'b1, 12'h04C, 1'b0};

    wr_v[0] = 1'b0; wr_pc[0] = 12'h000; wr_addr[0] = 12'hFF8;
    wr_v[1] = 1'b0; wr_pc[1] = 12'h000; wr_addr[1] = 12'hFFC;
    wr_v[2] = 1'b1; wr_pc[2] = 12'hFF8; wr_addr[2] = 12'h000;
    wr_v[3] = 1'b1; wr_pc[3] = 12'hFFC; wr_addr[3] = 12'h004;
    wr_v[4] = 1'b1; wr_pc[4] = 12'h000; wr_addr[4] = 12'h008;
    wr_v[5] = 1'b1; wr_pc[5] = 12'h004; wr_addr[5] = 12'h00C;

    // Reset, with fetch/redirect asserted to show reset wins.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 12'h043, 1'b1);
      check($sformatf("rst%0d req", i),   32'(rom_req),  32'd0);
      check($sformatf("rst%0d addr", i),  32'(rom_addr), 32'h000);
      check($sformatf("rst%0d valid", i), 32'(iv),       32'd0);
      check($sformatf("rst%0d instr", i), instr,         32'd0);
      check($sformatf("rst%0d mis", i),   32'(mis),      32'd0);
    end

    // Start-up stream, misaligned redirect with flush, fetch_en drop/re-enable.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, tbl[i].fe, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      check($sformatf("t%0d req", i),   32'(rom_req),  32'(tbl[i].req));
      check($sformatf("t%0d addr", i),  32'(rom_addr), 32'(tbl[i].addr));
      check($sformatf("t%0d valid", i), 32'(iv),       32'(tbl[i].v));
      check($sformatf("t%0d pc", i),    32'(ipc),      32'(tbl[i].pc));
      check($sformatf("t%0d instr", i), instr,
            tbl[i].v ? rom_word(tbl[i].pc) : 32'd0);
      check($sformatf("t%0d mis", i),   32'(mis),      32'(tbl[i].mis));
    end

    // Backpressure: redirect to 0x100 with ready low, FIFO fills to depth then stops.
    cyc(1'b0, 1'b1, 1'b1, 12'h100, 1'b0);
    check("bp redirect req", 32'(rom_req), 32'd0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
      if (rom_req) nreq++;
    end
    check("bp request count", 32'(nreq), 32'd4);
    check("bp req held low", 32'(rom_req), 32'd0);
    check("bp head valid", 32'(iv), 32'd1);
    check("bp head pc", 32'(ipc), 32'h100);
    got = 0;
    exp_pc = 12'h100;
    for (int k = 0; k < 40 && got < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 1'b1);
      if (iv) begin
        check($sformatf("drain%0d pc", got), 32'(ipc), 32'(exp_pc));
        check($sformatf("drain%0d instr", got), instr, rom_word(exp_pc));
        exp_pc = exp_pc + 12'h004;
        got++;
      end
    end
    check("drain count", 32'(got), 32'd8);

    // Stop fetching and drain completely.
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    check("idle empty", 32'(iv), 32'd0);
    check("idle no req", 32'(rom_req), 32'd0);

    // Redirect from idle to 0xFF8: 3-cycle latency and PC wrap.
    cyc(1'b0, 1'b1, 1'b1, 12'hFF8, 1'b1);
    check("wrap redirect req", 32'(rom_req), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 1'b1);
      check($sformatf("wrap%0d valid", k), 32'(iv),       32'(wr_v[k]));
      check($sformatf("wrap%0d pc", k),    32'(ipc),      32'(wr_pc[k]));
      check($sformatf("wrap%0d addr", k),  32'(rom_addr), 32'(wr_addr[k]));
      check($sformatf("wrap%0d req", k),   32'(rom_req),  32'd1);
    end

    // Reset mid-stream with the ROM valid stuck high.
    rom_hold = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    check("mrst valid", 32'(iv), 32'd0);
    check("mrst req", 32'(rom_req), 32'd0);
    check("mrst addr", 32'(rom_addr), 32'h000);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      check($sformatf("stale%0d valid", k), 32'(iv), 32'd0);
    end
    rom_hold = 1'b0;

`ifdef BOOT_FETCH_PERF_EN
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    check("perf rst fetched", perf_fetched, 32'd0);
    for (int k = 0; k < 13; k++) cyc(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    check("perf fetched", perf_fetched, 32'd4);
    check("perf stall", perf_stall, 32'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
